shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_sequencer_shifter.sv | 19 +
 rtl/shift_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer:
// FSM state encoding, operation encodings and the per-cycle step limit.
package shift_pkg;

  localparam int unsigned STEP_MAX = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// shifter: single-cycle zero-filling shifter with a 2-bit shift amount.
//   data_in  - operand
//   amt      - shift amount 0..3
//   left     - 1 = shift left, 0 = logical shift right
//   data_out - shifted operand (combinational)
module shifter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        amt,
  input  logic              left,
  output logic [DATA_W-1:0] data_out
);

  always_comb begin
    data_out = left ? (data_in << amt) : (data_in >> amt);
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRL/SRA built around a 2-bit shifter,
// applying at most STEP_MAX positions per cycle.
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   start   - request a shift (sampled only in IDLE)
//   abort   - cancel an in-flight shift (effective only in SHIFT)
//   op      - 00 SLL, 01 SRL, 10 SRA, 11 executes as SRL
//   shamt   - total shift amount 0..31
//   in_data - operand
//   busy    - high while not IDLE
//   done    - one-cycle pulse, result valid
//   result  - shifted value, held until the next completed operation
module shift_sequencer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned STEP_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        op,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  import shift_pkg::*;

  localparam logic [4:0] STEP_LIM = 5'(STEP_MAX);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [4:0]        rem_q, rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [4:0]        step;
  logic [4:0]        rem_after;
  logic              shift_left;
  logic              is_sra;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] fill_mask;
  logic [DATA_W-1:0] stepped;

  // Per-cycle step: min(remaining, STEP_MAX); never exceeds remaining.
  always_comb begin
    step       = (rem_q > STEP_LIM) ? STEP_LIM : rem_q;
    rem_after  = rem_q - step;
    shift_left = (op_q == OP_SLL);
    is_sra     = (op_q == OP_SRA);
  end

  shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .data_in  (data_q),
    .amt      (step[1:0]),
    .left     (shift_left),
    .data_out (shifted)
  );

  // SRA sign fill: the top 'step' bits are forced to the sign. data_q's MSB
  // stays equal to the original operand's sign throughout an SRA, so it
  // serves as the latched sign bit.
  always_comb begin
    fill_mask = ~({DATA_W{1'b1}} >> step);
    stepped   = (is_sra && data_q[DATA_W-1]) ? (shifted | fill_mask) : shifted;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SLL;
      data_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (shamt != 5'd0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rem_after == 5'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs: busy/done/result are computed from the
  // next state so that the output flops line up with the state they describe.
  always_comb begin
    data_d = data_q;
    op_d   = op_q;
    rem_d  = rem_q;
    if (state_q == ST_IDLE && start) begin
      data_d = in_data;
      op_d   = op_e'(op);
      rem_d  = shamt;
    end else if (state_q == ST_SHIFT) begin
      if (abort) begin
        rem_d = '0;
      end else begin
        data_d = stepped;
        rem_d  = rem_after;
      end
    end
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    result_d = done_d ? data_d : result_q;
  end

  always_comb begin
    busy   = busy_q;
    done   = done_q;
    result = result_q;
  end

endmodule
